// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared types and constants for the RISC-V immediate generator.
//               Holds the 3-bit immediate format encoding and the width of
//               each raw immediate field before it is extended to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_B     = 3'd2,
    FMT_U     = 3'd3,
    FMT_S     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  // Raw field widths, including the implicit zero LSB of B and J offsets
  localparam int c_IMM_W_I = 12;
  localparam int c_IMM_W_S = 12;
  localparam int c_IMM_W_B = 13;
  localparam int c_IMM_W_U = 32;
  localparam int c_IMM_W_J = 21;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational RISC-V immediate decoder. Extracts the immediate
//               field selected by fmt_i from instr_i and extends it to XLEN.
//               Format NONE yields zero and flags err_o.
// Ports       : instr_i - raw 32-bit instruction word
//               fmt_i   - immediate format code (see imm_fmt_e)
//               imm_o   - extended immediate, XLEN bits
//               err_o   - high when fmt_i is NONE
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      fmt_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  // Signed field views; a sized cast of a signed value sign-extends
  logic signed [c_IMM_W_I-1:0] w_fld_i;
  logic signed [c_IMM_W_S-1:0] w_fld_s;
  logic signed [c_IMM_W_B-1:0] w_fld_b;
  logic signed [c_IMM_W_U-1:0] w_fld_u;
  logic signed [c_IMM_W_J-1:0] w_fld_j;

  assign w_fld_i = instr_i[31:20];
  assign w_fld_s = {instr_i[31:25], instr_i[11:7]};
  assign w_fld_b = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_fld_u = {instr_i[31:12], 12'b0};
  assign w_fld_j = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (imm_fmt_e'(fmt_i))
      FMT_I:     imm_o = XLEN'(w_fld_i);
      FMT_S:     imm_o = XLEN'(w_fld_s);
      FMT_B:     imm_o = XLEN'(w_fld_b);
      FMT_U:     imm_o = XLEN'(w_fld_u);
      FMT_J:     imm_o = XLEN'(w_fld_j);
      // RV64 shifts use a 6-bit amount, RV32 a 5-bit one
      FMT_SHAMT: imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
      FMT_ZIMM:  imm_o = XLEN'(instr_i[19:15]);
      default: begin
        imm_o = '0;
        err_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Buffered immediate generator. Decodes the instruction
//               immediate combinationally and stores it, with a tag, in a
//               DEPTH-entry queue with valid/ready handshakes on both sides.
//               flush clears the queue for branch redirects.
// Ports       : clk, reset (async, active-low), flush (sync clear)
//               in_valid/in_ready, instr, fmt, in_tag  - producer side
//               out_valid/out_ready, imm, out_tag,
//               out_err                                - consumer side (head)
//               count                                  - queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [2:0]                 fmt,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            imm,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem_imm_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic             mem_err_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr_inc, rd_ptr_inc;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (instr),
    .fmt_i   (fmt),
    .imm_o   (dec_imm),
    .err_o   (dec_err)
  );

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH)) | (out_valid & out_ready);
  assign imm       = imm_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;
  assign count     = count_q;

  // flush overrides both sides of the handshake
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Explicit wrap: DEPTH need not be a power of two
  assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_inc = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    imm_d    = imm_q;
    tag_d    = tag_q;
    err_d    = err_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_inc;
      if (pop)  rd_ptr_d = rd_ptr_inc;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // The head registers only change when a new entry becomes the head;
      // when the queue drains they keep showing the last entry.
      if ((count_d != '0) && (pop || (count_q == '0))) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          imm_d = dec_imm;
          tag_d = in_tag;
          err_d = dec_err;
        end else begin
          imm_d = mem_imm_q[rd_ptr_d];
          tag_d = mem_tag_q[rd_ptr_d];
          err_d = mem_err_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      imm_q    <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm_q[i] <= '0;
        mem_tag_q[i] <= '0;
        mem_err_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      imm_q    <= imm_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
      if (push) begin
        mem_imm_q[wr_ptr_q] <= dec_imm;
        mem_tag_q[wr_ptr_q] <= in_tag;
        mem_err_q[wr_ptr_q] <= dec_err;
      end
    end
  end

endmodule
`default_nettype wire
